// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and coordinate type for the Pong video path.
package vga_pkg;

    localparam int VGA_CLK_DIV  = 4;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 0 = sync pulses are active-low, as the 640x480 mode expects
    localparam logic VGA_SYNC_ACT = 1'b0;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-rate enable: one-clk tick every CLK_DIV board clocks, so renderers stay on clk.
module pixel_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable, h/v counters, registered sync/visible/coordinate outputs.
// Build option VGA_SYNC_DELAY_EN delays h_sync, v_sync and video_on by one pixel period.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = VGA_CLK_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_ACT = VGA_SYNC_ACT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       video_on,
    output logic [9:0] x_loc,
    output logic [9:0] y_loc,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 2");
    end

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS_END  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic   tick;
    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_end;
    logic   v_end;
    logic   hs_act;
    logic   vs_act;
    logic   vis;
    logic   h_sync_r;
    logic   v_sync_r;
    logic   video_on_r;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_pixel_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    // Both counters wrap on the same tick at the last pixel of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        hs_act = 1'b0;
        vs_act = 1'b0;
        vis    = 1'b0;
        hs_act = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_act = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        vis    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    end

    // Every output is registered from the same counter state, giving a uniform one-clk lag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_loc      <= '0;
            y_loc      <= '0;
            video_on_r <= 1'b0;
            h_sync_r   <= ~SYNC_ACT;
            v_sync_r   <= ~SYNC_ACT;
            pix_tick   <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            x_loc      <= h_cnt;
            y_loc      <= v_cnt;
            video_on_r <= vis;
            h_sync_r   <= hs_act ? SYNC_ACT : ~SYNC_ACT;
            v_sync_r   <= vs_act ? SYNC_ACT : ~SYNC_ACT;
            pix_tick   <= tick;
            line_tick  <= tick && h_end;
            frame_tick <= tick && h_end && v_end;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic h_sync_d;
    logic v_sync_d;
    logic video_on_d;

    // Loads at the pixel boundary, so these trail x_loc/y_loc by exactly one pixel period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync_d   <= ~SYNC_ACT;
            v_sync_d   <= ~SYNC_ACT;
            video_on_d <= 1'b0;
        end else if (pix_tick) begin
            h_sync_d   <= h_sync_r;
            v_sync_d   <= v_sync_r;
            video_on_d <= video_on_r;
        end
    end

    assign h_sync   = h_sync_d;
    assign v_sync   = v_sync_d;
    assign video_on = video_on_d;
`else
    assign h_sync   = h_sync_r;
    assign v_sync   = v_sync_r;
    assign video_on = video_on_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width lines with a short frame so whole frames fit the run.
module tb_vga_timing_gen;

    localparam int D   = 4;
    localparam int HA  = 640;
    localparam int HFP = 16;
    localparam int HS  = 96;
    localparam int HT  = 800;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int W   = 26;
`ifdef VGA_SYNC_DELAY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_tick, h_sync, v_sync, video_on, line_tick, frame_tick;
    logic [9:0] x_loc, y_loc;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV (D),
        .V_ACTIVE(VA),
        .V_FP    (VFP),
        .V_SYNC  (VS),
        .V_BP    (VBP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_tick  (pix_tick),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .video_on  (video_on),
        .x_loc     (x_loc),
        .y_loc     (y_loc),
        .line_tick (line_tick),
        .frame_tick(frame_tick)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dut_vec;
    logic [W-1:0] exp_v;
    int           checks = 0;
    int           errors = 0;
    int           e = 0;

    assign dut_vec = {pix_tick, h_sync, v_sync, video_on, x_loc, y_loc, line_tick, frame_tick};

    // Expected outputs after the n-th clk edge since reset release (0 = in reset)
    function automatic logic [W-1:0] model(input int edge_n);
        int p, sub, h, v, ph, pv;
        logic tk, lt, ft, hs, vs, von;
        logic [9:0] hx, vy;
        if (edge_n == 0) return {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
        p   = (edge_n - 1) / D;
        sub = (edge_n - 1) % D;
        h   = p % HT;
        v   = (p / HT) % VT;
        tk  = (sub == D - 1);
        lt  = tk && (h == HT - 1);
        ft  = lt && (v == VT - 1);
        ph  = h;
        pv  = v;
`ifdef VGA_SYNC_DELAY_EN
        if (p > 0) begin
            ph = (p - 1) % HT;
            pv = ((p - 1) / HT) % VT;
        end
`endif
        hs  = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
        vs  = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
        von = (ph < HA) && (pv < VA);
`ifdef VGA_SYNC_DELAY_EN
        if (p == 0) begin
            hs  = 1'b1;
            vs  = 1'b1;
            von = 1'b0;
        end
`endif
        hx = h[9:0];
        vy = v[9:0];
        return {tk, hs, vs, von, hx, vy, lt, ft};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut_vec !== model(0)) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, model(0));
        end
        rst_n = 1'b1;
        e = 0;
        exp_q.delete();
    endtask

    task automatic test_first_tick();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            e++;
            exp_q.push_back(model(e));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL first_tick_sb e=%0d got=%h exp=%h", e, dut_vec, exp_v);
            end
            checks++;
            if (pix_tick !== (e == 4 || e == 8)) begin
                errors++;
                $display("FAIL first_pix_tick e=%0d got=%b exp=%b", e, pix_tick, (e == 4 || e == 8));
            end
            checks++;
            if (x_loc !== ((e >= 5) ? 10'd1 : 10'd0)) begin
                errors++;
                $display("FAIL first_x_loc e=%0d got=%0d exp=%0d", e, x_loc, (e >= 5) ? 1 : 0);
            end
        end
    endtask

    task automatic test_line();
        int last_lt = -1, lt_seen = 0, hs_fall = -1, hs_done = 0;
        logic prev_hs;
        prev_hs = h_sync;
        for (int i = 0; i < 8000 && !(lt_seen >= 2 && hs_done == 1); i++) begin
            @(posedge clk);
            e++;
            exp_q.push_back(model(e));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL line_sb e=%0d got=%h exp=%h", e, dut_vec, exp_v);
            end
            if (line_tick === 1'b1) begin
                if (last_lt >= 0) begin
                    checks++;
                    if (e - last_lt != HT * D) begin
                        errors++;
                        $display("FAIL line_period got=%0d exp=%0d", e - last_lt, HT * D);
                    end
                end
                last_lt = e;
                lt_seen++;
            end
            if (prev_hs === 1'b1 && h_sync === 1'b0) begin
                hs_fall = e;
                checks++;
                if (x_loc !== 10'(HA + HFP + LAG)) begin
                    errors++;
                    $display("FAIL hsync_start_x got=%0d exp=%0d", x_loc, HA + HFP + LAG);
                end
            end
            if (prev_hs === 1'b0 && h_sync === 1'b1 && hs_fall >= 0) begin
                checks++;
                if (e - hs_fall != HS * D) begin
                    errors++;
                    $display("FAIL hsync_width got=%0d exp=%0d", e - hs_fall, HS * D);
                end
                hs_done = 1;
            end
            prev_hs = h_sync;
        end
        checks++;
        if (!(lt_seen >= 2 && hs_done == 1)) begin
            errors++;
            $display("FAIL line_timeout got lt=%0d hs_done=%0d exp lt=2 hs_done=1", lt_seen, hs_done);
        end
    endtask

    task automatic test_frame();
        int last_ft = -1, ft_seen = 0, wrap_at = -1, vs_fall = -1, vs_done = 0;
        logic prev_vs;
        prev_vs = v_sync;
        for (int i = 0; i < 60000 && !(ft_seen >= 2 && vs_done == 1 && wrap_at < 0); i++) begin
            @(posedge clk);
            e++;
            exp_q.push_back(model(e));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL frame_sb e=%0d got=%h exp=%h", e, dut_vec, exp_v);
            end
            if (e == wrap_at) begin
                checks++;
                if (x_loc !== 10'd0 || y_loc !== 10'd0) begin
                    errors++;
                    $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", x_loc, y_loc);
                end
                wrap_at = -1;
            end
            if (frame_tick === 1'b1) begin
                checks++;
                if (line_tick !== 1'b1 || x_loc !== 10'(HT - 1) || y_loc !== 10'(VT - 1)) begin
                    errors++;
                    $display("FAIL frame_end got lt=%b (%0d,%0d) exp lt=1 (%0d,%0d)",
                             line_tick, x_loc, y_loc, HT - 1, VT - 1);
                end
                if (last_ft >= 0) begin
                    checks++;
                    if (e - last_ft != HT * VT * D) begin
                        errors++;
                        $display("FAIL frame_period got=%0d exp=%0d", e - last_ft, HT * VT * D);
                    end
                end
                last_ft = e;
                wrap_at = e + 1;
                ft_seen++;
            end
            if (prev_vs === 1'b1 && v_sync === 1'b0) begin
                vs_fall = e;
                checks++;
                if (y_loc !== 10'(VA + VFP) || x_loc !== 10'(LAG)) begin
                    errors++;
                    $display("FAIL vsync_start got=(%0d,%0d) exp=(%0d,%0d)", x_loc, y_loc, LAG, VA + VFP);
                end
            end
            if (v_sync === 1'b0) begin
                checks++;
                if (y_loc < 10'(VA + VFP) || y_loc > 10'(VA + VFP + VS - 1 + LAG)) begin
                    errors++;
                    $display("FAIL vsync_line got y=%0d exp in %0d..%0d", y_loc, VA + VFP, VA + VFP + VS - 1 + LAG);
                end
            end
            if (prev_vs === 1'b0 && v_sync === 1'b1 && vs_fall >= 0) begin
                checks++;
                if (e - vs_fall != VS * HT * D) begin
                    errors++;
                    $display("FAIL vsync_width got=%0d exp=%0d", e - vs_fall, VS * HT * D);
                end
                vs_done = 1;
            end
            prev_vs = v_sync;
            if (x_loc == 10'(HA - 1 + LAG)) begin
                checks++;
                if (video_on !== (y_loc < 10'(VA))) begin
                    errors++;
                    $display("FAIL vis_x639 y=%0d got=%b exp=%b", y_loc, video_on, (y_loc < 10'(VA)));
                end
            end
            if (x_loc == 10'(HA + LAG)) begin
                checks++;
                if (video_on !== 1'b0) begin
                    errors++;
                    $display("FAIL vis_x640 y=%0d got=%b exp=0", y_loc, video_on);
                end
            end
            if (x_loc == 10'd100 && (y_loc == 10'(VA - 1) || y_loc == 10'(VA))) begin
                checks++;
                if (video_on !== (y_loc == 10'(VA - 1))) begin
                    errors++;
                    $display("FAIL vis_y_edge y=%0d got=%b exp=%b", y_loc, video_on, (y_loc == 10'(VA - 1)));
                end
            end
        end
        checks++;
        if (!(ft_seen >= 2 && vs_done == 1)) begin
            errors++;
            $display("FAIL frame_timeout got ft=%0d vs_done=%0d exp ft=2 vs_done=1", ft_seen, vs_done);
        end
    endtask

    task automatic test_mid_reset();
        int found = 0;
        for (int i = 0; i < 30000 && found == 0; i++) begin
            @(posedge clk);
            e++;
            exp_q.push_back(model(e));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL pre_reset_sb e=%0d got=%h exp=%h", e, dut_vec, exp_v);
            end
            if (x_loc == 10'd300 && y_loc == 10'd2) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL mid_reset_reach got=(%0d,%0d) exp=(300,2)", x_loc, y_loc);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== model(0)) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, model(0));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut_vec !== model(0)) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", dut_vec, model(0));
        end
        rst_n = 1'b1;
        e = 0;
        exp_q.delete();
        for (int i = 0; i < HT * D + 100; i++) begin
            @(posedge clk);
            e++;
            exp_q.push_back(model(e));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL post_reset_sb e=%0d got=%h exp=%h", e, dut_vec, exp_v);
            end
            if (e == 5) begin
                checks++;
                if (x_loc !== 10'd1 || y_loc !== 10'd0) begin
                    errors++;
                    $display("FAIL restart_coord got=(%0d,%0d) exp=(1,0)", x_loc, y_loc);
                end
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_frame();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
